// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/DONE control, LUT jumps and branches, run-cycle counter.
// Optional return stack is enabled by defining PC_CALL_STACK_EN.
module pc_sequencer #(
   parameter int D           = 9,
   parameter int A           = 5,
   parameter int START_PC    = 0,
   parameter int CW          = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic          halt_i,
   input  logic          stall_i,
   input  logic          jump_i,
   input  logic          branch_i,
   input  logic          taken_i,
   input  logic [A-1:0]  lut_idx_i,
   input  logic [D-1:0]  target_i,
   input  logic          call_i,
   input  logic          ret_i,
   output logic [A-1:0]  lut_addr_o,
   output logic [D-1:0]  prog_ctr_o,
   output logic          running_o,
   output logic          done_o,
   output logic          overrun_o,
   output logic [CW-1:0] cycle_cnt_o,
   output logic          stack_err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [D-1:0] START_VAL = D'(START_PC);

   logic [1:0]    state_q, state_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovr_q, ovr_d;
   logic          running_q, done_q;
   logic          do_inc;

`ifdef PC_CALL_STACK_EN
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [D-1:0]   stack_q [STACK_DEPTH];
   logic [SPW-1:0] sp_q, sp_d;
   logic [IW-1:0]  wr_idx, rd_idx;
   logic           err_q, err_d;
   logic           push;
   logic           full, empty;

   assign wr_idx = sp_q[IW-1:0];
   assign rd_idx = wr_idx - 1'b1;
   assign full   = (sp_q == SPW'(STACK_DEPTH));
   assign empty  = (sp_q == '0);
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      do_inc  = 1'b0;
`ifdef PC_CALL_STACK_EN
      sp_d    = sp_q;
      err_d   = err_q;
      push    = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_RUN;
               pc_d    = START_VAL;
               cnt_d   = '0;
               ovr_d   = 1'b0;
`ifdef PC_CALL_STACK_EN
               sp_d    = '0;
               err_d   = 1'b0;
`endif
            end
         end
         S_RUN: begin
            // Counts every RUN cycle, the halting cycle included.
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (halt_i) begin
               state_d = S_DONE;
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (jump_i || (branch_i && taken_i)) begin
               pc_d = target_i;
`ifdef PC_CALL_STACK_EN
            end else if (call_i) begin
               if (full) begin
                  err_d  = 1'b1;
                  do_inc = 1'b1;
               end else begin
                  push = 1'b1;
                  sp_d = sp_q + 1'b1;
                  pc_d = target_i;
               end
            end else if (ret_i) begin
               if (empty) begin
                  err_d  = 1'b1;
                  do_inc = 1'b1;
               end else begin
                  sp_d = sp_q - 1'b1;
                  pc_d = stack_q[rd_idx];
               end
`endif
            end else begin
               do_inc = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Running off the end of the ROM stops the program instead of wrapping.
      if (do_inc) begin
         if (&pc_q) begin
            state_d = S_DONE;
            ovr_d   = 1'b1;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         ovr_q     <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         ovr_q     <= ovr_d;
         running_q <= (state_d == S_RUN);
         done_q    <= (state_d == S_DONE);
      end
   end

`ifdef PC_CALL_STACK_EN
   always_ff @(posedge clk) begin
      if (reset_i) begin
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_i && push) begin
         stack_q[wr_idx] <= pc_q + 1'b1;
      end
   end

   assign stack_err_o = err_q;
`else
   logic unused_stack;
   assign unused_stack = &{1'b0, call_i, ret_i, STACK_DEPTH[0]};
   assign stack_err_o  = 1'b0;
`endif

   assign lut_addr_o  = lut_idx_i;
   assign prog_ctr_o  = pc_q;
   assign running_o   = running_q;
   assign done_o      = done_q;
   assign overrun_o   = ovr_q;
   assign cycle_cnt_o = cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle core.
- Owns the architectural PC and sequences fetch from program start to halt.
- Drives the branch-target LUT index and applies the looked-up absolute target on jump or taken branch.
- Provides a start/done handshake and a run-cycle counter to the top level.

Parameters:
- D, 9, PC width in bits; instruction ROM depth 2^D.
- A, 5, branch-target LUT index width.
- START_PC, 0, PC value loaded on start.
- CW, 16, run-cycle counter width.
- STACK_DEPTH, 4, return-stack entries (used only with optional feature).

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level; begin/restart program when in IDLE or DONE.
- Halt  input  1  decoder: current instruction is halt.
- Stall  input  1  hold PC this cycle (multi-cycle data memory).
- Jump  input  1  decoder: unconditional LUT jump.
- Branch  input  1  decoder: conditional LUT branch.
- Taken  input  1  ALU condition flag for Branch.
- LutIdx  input  A  LUT index field from instruction.
- Target  input  D  LUT output (combinational from LutAddr).
- Call  input  1  decoder: call (optional feature).
- Ret  input  1  decoder: return (optional feature).
- LutAddr  output  A  combinational copy of LutIdx.
- ProgCtr  output  D  registered PC to instruction ROM.
- Running  output  1  high in RUN.
- Done  output  1  high in DONE.
- Overrun  output  1  sticky; PC ran past 2^D-1 without halt.
- CycleCnt  output  CW  RUN cycles since last start.
- StackErr  output  1  sticky return-stack fault.

Behaviour:
- Reset: state IDLE; ProgCtr=0, Done=0, Running=0, Overrun=0, CycleCnt=0, StackErr=0, stack pointer=0.
- Reset in any state, including mid-RUN, forces these values at the next edge.
- States are IDLE, RUN and DONE.
- IDLE:
  - Start=1 -> RUN; ProgCtr<=START_PC; CycleCnt<=0; Overrun<=0; StackErr<=0.
  - Otherwise hold.
- RUN priority, highest first, one action per cycle:
  1. Halt -> DONE, ProgCtr holds.
  2. Stall -> hold ProgCtr.
  3. Jump, or Branch&Taken -> ProgCtr<=Target, zero bubble.
  4. Call/Ret (feature only).
  5. Otherwise ProgCtr<=ProgCtr+1.
- Branch&!Taken behaves as increment.
- Jump and Branch both high: treat as Jump.
- Increment from ProgCtr=2^D-1 -> DONE with Overrun=1; ProgCtr holds at 2^D-1, no wrap.
- CycleCnt increments every RUN cycle, including stall and halt cycles; saturates at 2^CW-1.
- Done and Running are registered from state; Done stays high until restart or Reset.
- DONE:
  - Start=1 -> same as IDLE start; Done<=0 on that edge.
  - Start already high on DONE entry restarts on the following cycle.
  - Start held continuously relaunches after each halt (top level must drop Start).
- Inputs other than Start and Reset are ignored outside RUN.
- LutAddr=LutIdx at all times. Target is sampled only when applied.

Optional Feature:
- Macro: PC_CALL_STACK_EN.
- Enabled: a return stack of STACK_DEPTH entries, each D bits.
  - Call -> push ProgCtr+1; ProgCtr<=Target.
  - Ret -> pop; ProgCtr<=popped value.
  - Call while full -> no push, treated as increment, StackErr<=1.
  - Ret while empty -> increment, StackErr<=1.
  - Call and Ret both high -> Call wins.
  - Stack pointer clears on Reset and on start.
- Disabled:
  - No stack storage.
  - Call and Ret are ignored; both behave as increment.
  - StackErr is tied to 0.
  - Ports remain so the top level is unchanged.

Test Plan:
- Reset, Start=1 one cycle, no decoder inputs -> ProgCtr 0,1,2,3...; Running=1 from second cycle; CycleCnt tracks.
- At ProgCtr=5: Jump, LutIdx=3, Target=221 -> LutAddr=3, next ProgCtr=221.
- Branch with Taken=0 at PC 10 -> 11; Branch with Taken=1, Target=174 -> 174.
- Stall 3 cycles at PC 20 -> PC stays 20 for 3 cycles then 21.
- Halt together with Jump at PC 30 -> DONE, ProgCtr=30, Done=1; then Start -> PC=0, Done=0, CycleCnt=0.
- Run from 508 with no halt (D=9) -> PC stops at 511, Done=1, Overrun=1.
- Reset asserted mid-RUN at PC 40 -> next edge IDLE, all outputs 0.
- With PC_CALL_STACK_EN:
  - Call at PC 7 to Target 300, then Ret -> PC 8.
  - Five nested Calls -> StackErr=1.
  - Ret on empty stack -> increment, StackErr=1.
